hazard_sched: RTL
=================

Name: hazard_sched

Overview:
- Pipeline scheduler for the 5-stage RV32I core.
- Drives the hold/clear inputs of every stage's control and data pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, branch/jump redirects and data-memory wait states; selects EX-stage forwarding sources.
- Owns a small FSM for multi-cycle memory waits with a timeout, plus saturating performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive dmem wait cycles before error (>=1)
PERF_W, 32, width of performance counters

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
rs1_d  input  5  source reg 1 of instr in D
rs2_d  input  5  source reg 2 of instr in D
rs1_e  input  5  source reg 1 of instr in E
rs2_e  input  5  source reg 2 of instr in E
rd_e  input  5  dest reg in E
rd_m  input  5  dest reg in M
rd_w  input  5  dest reg in W
regwrite_e  input  1  E instr writes rd
regwrite_m  input  1  M instr writes rd
regwrite_w  input  1  W instr writes rd
memtoreg_e  input  1  E instr is a load
pcsrc_e  input  1  taken branch/jump/jalr resolved in E
dmem_req_m  input  1  M instr accesses data memory (load or store)
dmem_ready  input  1  data memory completes access this cycle
stall_f  output  1  hold PC
stall_d  output  1  hold IF/ID
stall_e  output  1  hold ID/EX
stall_m  output  1  hold EX/MEM
flush_d  output  1  clear IF/ID
flush_e  output  1  clear ID/EX
flush_w  output  1  clear MEM/WB (bubble)
fwd_a_e  output  2  ALU operand A source: 00 regfile, 10 M result, 01 W result
fwd_b_e  output  2  ALU operand B source, same encoding
mem_err  output  1  sticky dmem timeout error
stall_cycles  output  PERF_W  count of cycles with stall_f=1
redirects  output  PERF_W  count of accepted redirects

Behaviour:
- Hold (stall_x=1) keeps the register contents. Clear has priority over hold at the register.
- All stall/flush/fwd outputs are combinational from state and inputs. Counters, state and mem_err are registered.
- Reset (whole cycle asserted):
  - state<=RUN, wait_cnt<=0, mem_err<=0, counters<=0.
  - Outputs during reset: flush_d=flush_e=flush_w=1, all stall_*=0, fwd=00.
  - Reset mid-MEM_WAIT or in ERR returns the FSM to RUN.
- FSM states RUN, MEM_WAIT, ERR.
  - memwait = dmem_req_m & ~dmem_ready.
  - RUN: memwait -> MEM_WAIT, else stay.
  - MEM_WAIT: ~memwait -> RUN. memwait & wait_cnt==MEM_TIMEOUT-1 -> ERR. Otherwise stay.
  - ERR: absorbing until reset; mem_err=1 registered on entry.
- wait_cnt:
  - Increments on every memwait cycle in RUN or MEM_WAIT.
  - Clears on any non-memwait cycle.
  - Max MEM_TIMEOUT memwait stall cycles occur before ERR.
- Priority per cycle, highest first:
  1. ERR: stall_f/d/e/m=1, flush_w=1, flush_d=flush_e=0.
  2. memwait (RUN or MEM_WAIT): stall_f/d/e/m=1, flush_w=1. A pcsrc_e or load-use condition present that cycle is ignored; E is frozen, so it is re-evaluated after the wait.
  3. pcsrc_e: flush_d=1, flush_e=1, no stalls. redirects increments.
  4. Load-use: memtoreg_e & regwrite_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d) gives stall_f=stall_d=1, flush_e=1.
  5. Otherwise all outputs 0.
- Forwarding (valid in every state):
  - fwd_a_e=10 if regwrite_m & rd_m!=0 & rd_m==rs1_e.
  - Else 01 if regwrite_w & rd_w!=0 & rd_w==rs1_e.
  - Else 00.
  - fwd_b_e is the same using rs2_e. The M match wins over W. x0 is never forwarded.
- Counters saturate at all-ones.
  - stall_cycles increments each non-reset cycle with stall_f=1.
  - redirects increments only when priority case 3 is taken.

Test Plan:
- Load-use: memtoreg_e=1, regwrite_e=1, rd_e=5, rs2_d=5 -> stall_f=stall_d=1, flush_e=1 for exactly 1 cycle; stall_cycles=1. Repeat with rd_e=0 -> no stall.
- Redirect: pcsrc_e=1 for 1 cycle -> flush_d=flush_e=1 that cycle, redirects=1. Same with simultaneous load-use condition -> flush only, stall_f=0.
- Forwarding: rs1_e=7, rd_m=7, rd_w=7, regwrite_m=regwrite_w=1 -> fwd_a_e=10. Set regwrite_m=0 -> 01. Set rs1_e=rd_m=rd_w=0 -> 00.
- Memory wait: dmem_req_m=1, dmem_ready low 3 cycles then high -> stall_f/d/e/m and flush_w high exactly 3 cycles. pcsrc_e=1 held throughout -> redirect asserted only on the 4th cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> ERR entered after 4 stall cycles, mem_err=1, stalls held. Then reset 1 cycle -> state RUN, mem_err=0, counters 0, flush_* =1 during reset.
- Saturation: PERF_W=4, continuous load-use stall for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/hazard_sched.sv
// hazard_sched: stall/flush/forwarding control for the 5-stage RV32I pipeline.
// Handles load-use interlocks, E-stage redirects, data-memory wait states with
// a timeout, and keeps saturating counters of stall cycles and redirects.
module hazard_sched #(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rs1_e,
  input  logic [4:0]        rs2_e,
  input  logic [4:0]        rd_e,
  input  logic [4:0]        rd_m,
  input  logic [4:0]        rd_w,
  input  logic              regwrite_e,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              memtoreg_e,
  input  logic              pcsrc_e,
  input  logic              dmem_req_m,
  input  logic              dmem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              mem_err,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] redirects
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR      = 2'd2;

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] redirects_q, redirects_d;

  logic memwait;
  logic in_err;
  logic load_use;
  logic redirect_taken;

  assign memwait  = dmem_req_m & ~dmem_ready;
  assign in_err   = (state_q == ST_ERR);
  assign load_use = memtoreg_e & regwrite_e & (rd_e != 5'd0) &
                    ((rd_e == rs1_d) | (rd_e == rs2_d));

  // Prioritised stall/flush selection: reset, ERR, memory wait, redirect, load-use.
  always_comb begin
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    stall_e        = 1'b0;
    stall_m        = 1'b0;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    flush_w        = 1'b0;
    redirect_taken = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (in_err || memwait) begin
      // Whole pipe frozen; E is re-evaluated once the access completes.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pcsrc_e) begin
      flush_d        = 1'b1;
      flush_e        = 1'b1;
      redirect_taken = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Forwarding: M result beats W result, x0 never forwarded, forced off in reset.
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (!reset) begin
      if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs1_e))
        fwd_a_e = 2'b10;
      else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs1_e))
        fwd_a_e = 2'b01;
      if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs2_e))
        fwd_b_e = 2'b10;
      else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs2_e))
        fwd_b_e = 2'b01;
    end
  end

  // Memory-wait FSM, wait counter and sticky timeout error.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      ST_RUN: begin
        if (memwait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!memwait) begin
          state_d = ST_RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          // >= keeps the timeout reachable even for MEM_TIMEOUT of 1.
          if (wait_cnt_q >= CNT_LAST)
            state_d = ST_ERR;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
    mem_err_d = mem_err_q | (state_d == ST_ERR);
  end

  // Saturating performance counters; stall_f is already 0 during reset.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    redirects_d    = redirects_q;
    if (stall_f && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (redirect_taken && !(&redirects_q))
      redirects_d = redirects_q + 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
      redirects_q    <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
      redirects_q    <= redirects_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;
  assign redirects    = redirects_q;

endmodule
